// File: rtl/pipe_de_vec.sv
// Decode-to-execute pipeline register for the vector datapath.
// Holds on stall, inserts bubbles on flush or empty decode, and counts inserted bubbles.
module pipe_de_vec #(
   parameter int WIDTH     = 32,
   parameter int LANES     = 4,
   parameter int REG_BITS  = 5,
   parameter int CNT_WIDTH = 16
) (
   input  logic                   CLK,
   input  logic                   CLR_N,
   input  logic                   STALL,
   input  logic                   FLUSH,
   input  logic                   VALID_D,
   input  logic                   VEC_D,
   input  logic [LANES-1:0]       LANE_MASK_D,
   input  logic                   REG_WRITE_D,
   input  logic                   MEM_TO_REG_D,
   input  logic                   MEM_WRITE_D,
   input  logic [3:0]             ALU_CONTROL_D,
   input  logic [1:0]             ALU_SRC_D,
   input  logic [LANES*WIDTH-1:0] RD1_D,
   input  logic [LANES*WIDTH-1:0] RD2_D,
   input  logic [REG_BITS-1:0]    RA1_D,
   input  logic [REG_BITS-1:0]    RA2_D,
   input  logic [REG_BITS-1:0]    WRITE_REG_D,
   input  logic [WIDTH-1:0]       SIGN_IMM_D,
   input  logic [2:0]             SHIFT_D,
   output logic                   VALID_E,
   output logic                   VEC_E,
   output logic [LANES-1:0]       LANE_MASK_E,
   output logic                   REG_WRITE_E,
   output logic                   MEM_TO_REG_E,
   output logic                   MEM_WRITE_E,
   output logic [3:0]             ALU_CONTROL_E,
   output logic [1:0]             ALU_SRC_E,
   output logic [LANES*WIDTH-1:0] RD1_E,
   output logic [LANES*WIDTH-1:0] RD2_E,
   output logic [REG_BITS-1:0]    RA1_E,
   output logic [REG_BITS-1:0]    RA2_E,
   output logic [REG_BITS-1:0]    WRITE_REG_E,
   output logic [WIDTH-1:0]       SIGN_IMM_E,
   output logic [2:0]             SHIFT_E,
   output logic [CNT_WIDTH-1:0]   BUBBLE_COUNT
);

   localparam logic [3:0] ALU_NOP = 4'hF;

   logic                   load_bubble;
   logic                   no_lanes;
   logic [LANES-1:0]       eff_mask;
   logic [LANES*WIDTH-1:0] rd1_masked;
   logic [LANES*WIDTH-1:0] rd2_masked;

   // Scalar ops always occupy lane 0 alone; vector ops use the decoded mask.
   always_comb begin
      load_bubble = FLUSH | (~STALL & ~VALID_D);
      eff_mask    = VEC_D ? LANE_MASK_D : LANES'(1);
      no_lanes    = VEC_D & ~(|LANE_MASK_D);
      rd1_masked  = '0;
      rd2_masked  = '0;
      for (int i = 0; i < LANES; i++) begin
         if (eff_mask[i]) begin
            rd1_masked[i*WIDTH +: WIDTH] = RD1_D[i*WIDTH +: WIDTH];
            rd2_masked[i*WIDTH +: WIDTH] = RD2_D[i*WIDTH +: WIDTH];
         end
      end
   end

   // State changes on the falling edge; flush outranks stall, stall outranks load.
   always_ff @(negedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         VALID_E       <= 1'b0;
         VEC_E         <= 1'b0;
         LANE_MASK_E   <= '0;
         REG_WRITE_E   <= 1'b0;
         MEM_TO_REG_E  <= 1'b0;
         MEM_WRITE_E   <= 1'b0;
         ALU_CONTROL_E <= ALU_NOP;
         ALU_SRC_E     <= '0;
         RD1_E         <= '0;
         RD2_E         <= '0;
         RA1_E         <= '0;
         RA2_E         <= '0;
         WRITE_REG_E   <= '0;
         SIGN_IMM_E    <= '0;
         SHIFT_E       <= '0;
         BUBBLE_COUNT  <= '0;
      end else if (load_bubble) begin
         VALID_E       <= 1'b0;
         VEC_E         <= 1'b0;
         LANE_MASK_E   <= '0;
         REG_WRITE_E   <= 1'b0;
         MEM_TO_REG_E  <= 1'b0;
         MEM_WRITE_E   <= 1'b0;
         ALU_CONTROL_E <= ALU_NOP;
         ALU_SRC_E     <= '0;
         RD1_E         <= '0;
         RD2_E         <= '0;
         RA1_E         <= '0;
         RA2_E         <= '0;
         WRITE_REG_E   <= '0;
         SIGN_IMM_E    <= '0;
         SHIFT_E       <= '0;
         if (BUBBLE_COUNT != '1) begin
            BUBBLE_COUNT <= BUBBLE_COUNT + CNT_WIDTH'(1);
         end
      end else if (!STALL) begin
         VALID_E       <= 1'b1;
         VEC_E         <= VEC_D;
         LANE_MASK_E   <= eff_mask;
         REG_WRITE_E   <= REG_WRITE_D & ~no_lanes;
         MEM_TO_REG_E  <= MEM_TO_REG_D;
         MEM_WRITE_E   <= MEM_WRITE_D & ~no_lanes;
         ALU_CONTROL_E <= ALU_CONTROL_D;
         ALU_SRC_E     <= ALU_SRC_D;
         RD1_E         <= rd1_masked;
         RD2_E         <= rd2_masked;
         RA1_E         <= RA1_D;
         RA2_E         <= RA2_D;
         WRITE_REG_E   <= WRITE_REG_D;
         SIGN_IMM_E    <= SIGN_IMM_D;
         SHIFT_E       <= SHIFT_D;
      end
   end

endmodule
